sram_march_bist: RTL and testbench

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

---
 rtl/openram_bist_pkg.sv | 48 ++++
 rtl/bist_fail_logger.sv | 70 +++++++
 rtl/sram_march_bist.sv | 166 ++++++++++++++++
 tb/tb_sram_march_bist.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/openram_bist_pkg.sv
// Shared encodings, default widths and element helpers for the March C- BIST.
package openram_bist_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_WMASK_W   = 4;
    localparam int DEF_NUM_CHIPS = 16;
    localparam int SEL_W         = 4;
    localparam int FAIL_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        DONE_ST = 2'd3
    } bist_state_t;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } march_elem_t;

    // March C-: E0 W0 up; E1 R0,W1 up; E2 R1,W0 up; E3 R0,W1 down; E4 R1,W0 down; E5 R0 down
    function automatic logic elem_has_read(input march_elem_t e);
        return e != E0;
    endfunction

    function automatic logic elem_has_write(input march_elem_t e);
        return e != E5;
    endfunction

    function automatic logic elem_is_down(input march_elem_t e);
        return e inside {E3, E4, E5};
    endfunction

    function automatic logic elem_read_ones(input march_elem_t e);
        return e inside {E2, E4};
    endfunction

    function automatic logic elem_write_ones(input march_elem_t e);
        return e inside {E1, E3};
    endfunction

endpackage

// File: rtl/bist_fail_logger.sv
// Compares each read one cycle after issue and records the first failing
// address/element plus a saturating miscompare count.
module bist_fail_logger
    import openram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  rd_issue,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  march_elem_t           rd_elem,
    input  logic [DATA_W-1:0]     rd_exp,
    input  logic [DATA_W-1:0]     cmp_mask,
    input  logic [DATA_W-1:0]     dout,
    output logic                  fail,
    output logic [ADDR_W-1:0]     fail_addr,
    output logic [2:0]            fail_elem,
    output logic [FAIL_CNT_W-1:0] fail_count
);

    logic              pend;
    logic [ADDR_W-1:0] addr_q;
    march_elem_t       elem_q;
    logic [DATA_W-1:0] exp_q;
    logic              miscompare;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend   <= 1'b0;
            addr_q <= '0;
            elem_q <= E0;
            exp_q  <= '0;
        end else begin
            pend   <= rd_issue && !clear;
            addr_q <= rd_addr;
            elem_q <= rd_elem;
            exp_q  <= rd_exp;
        end
    end

    assign miscompare = pend && (((dout ^ exp_q) & cmp_mask) != '0);

    // Only the first miscompare of a run latches location; later ones just count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
        end else if (clear) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
        end else if (miscompare) begin
            if (!fail) begin
                fail_addr <= addr_q;
                fail_elem <= elem_q;
            end
            fail <= 1'b1;
            if (fail_count != {FAIL_CNT_W{1'b1}}) begin
                fail_count <= fail_count + {{(FAIL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST engine driving one OpenRAM macro port, one SRAM operation
// per cycle, with a single drain cycle to check the final read.
module sram_march_bist
    import openram_bist_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WMASK_W   = DEF_WMASK_W,
    parameter int NUM_CHIPS = DEF_NUM_CHIPS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [SEL_W-1:0]      chip_sel,
    input  logic [ADDR_W-1:0]     last_addr,
    input  logic [DATA_W-1:0]     pattern,
    input  logic [DATA_W-1:0]     cmp_mask,
    input  logic [DATA_W-1:0]     dout,
    output logic [NUM_CHIPS-1:0]  csb,
    output logic                  web,
    output logic [WMASK_W-1:0]    wmask,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     din,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_W-1:0]     fail_addr,
    output logic [2:0]            fail_elem,
    output logic [FAIL_CNT_W-1:0] fail_count
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    bist_state_t       state, state_d;
    march_elem_t       elem, elem_d;
    logic              phase, phase_d;
    logic [ADDR_W-1:0] cur_addr, addr_d;
    logic              done_q, done_d;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] pat_q;
    logic [DATA_W-1:0] mask_q;

    logic              start_ok;
    logic              has_rd, has_wr, is_rd, is_wr, addr_last_op;
    logic [ADDR_W-1:0] end_addr;
    logic [DATA_W-1:0] wr_word, rd_exp;

    assign start_ok = start && (state == IDLE || state == DONE_ST);

    // phase 0 is the read of an R,W pair, phase 1 its write to the same address
    always_comb begin
        has_rd       = elem_has_read(elem);
        has_wr       = elem_has_write(elem);
        is_rd        = (state == RUN) && has_rd && !phase;
        is_wr        = (state == RUN) && has_wr && (phase || !has_rd);
        addr_last_op = !(has_rd && has_wr) || phase;
        end_addr     = elem_is_down(elem) ? '0 : last_q;
        wr_word      = elem_write_ones(elem) ? ~pat_q : pat_q;
        rd_exp       = elem_read_ones(elem) ? ~pat_q : pat_q;
    end

    always_comb begin
        state_d = state;
        elem_d  = elem;
        phase_d = phase;
        addr_d  = cur_addr;
        done_d  = done_q;
        case (state)
            IDLE, DONE_ST: begin
                if (start_ok) begin
                    state_d = RUN;
                    elem_d  = E0;
                    phase_d = 1'b0;
                    addr_d  = '0;
                    done_d  = 1'b0;
                end else if (state == DONE_ST) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!addr_last_op) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    // Bound check precedes the step, so the address never wraps.
                    if (cur_addr != end_addr) begin
                        addr_d = elem_is_down(elem) ? cur_addr - ADDR_ONE : cur_addr + ADDR_ONE;
                    end else if (elem == E5) begin
                        state_d = DRAIN;
                    end else begin
                        elem_d = march_elem_t'(elem + 3'd1);
                        addr_d = elem_is_down(elem_d) ? last_q : '0;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE_ST;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            elem     <= E0;
            phase    <= 1'b0;
            cur_addr <= '0;
            done_q   <= 1'b0;
            sel_q    <= '0;
            last_q   <= '0;
            pat_q    <= '0;
            mask_q   <= '0;
        end else begin
            state    <= state_d;
            elem     <= elem_d;
            phase    <= phase_d;
            cur_addr <= addr_d;
            done_q   <= done_d;
            if (start_ok) begin
                sel_q  <= chip_sel;
                last_q <= last_addr;
                pat_q  <= pattern;
                mask_q <= cmp_mask;
            end
        end
    end

    always_comb begin
        csb   = '1;
        web   = !is_wr;
        wmask = is_wr ? '1 : '0;
        addr  = (is_rd || is_wr) ? cur_addr : '0;
        din   = is_wr ? wr_word : '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if ((is_rd || is_wr) && int'(sel_q) == i) begin
                csb[i] = 1'b0;
            end
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = done_q;

    bist_fail_logger #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fail_logger (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start_ok),
        .rd_issue   (is_rd),
        .rd_addr    (cur_addr),
        .rd_elem    (elem),
        .rd_exp     (rd_exp),
        .cmp_mask   (mask_q),
        .dout       (dout),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_count (fail_count)
    );

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: SRAM model with optional stuck-at-0 cell, March C-
// reference model feeding op and result scoreboards.
module tb_sram_march_bist;

    localparam int AW        = 16;
    localparam int DW        = 32;
    localparam int MW        = 4;
    localparam int NC        = 16;
    localparam int RUN_BOUND = 2000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [3:0]    chip_sel;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] pattern;
    logic [DW-1:0] cmp_mask;
    logic [DW-1:0] dout;
    logic [NC-1:0] csb;
    logic          web;
    logic [MW-1:0] wmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          busy;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [7:0]    fail_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
    } exp_op_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          web;
        logic [DW-1:0] din;
        logic [MW-1:0] wmask;
        logic [NC-1:0] csb;
    } obs_op_t;

    typedef struct {
        int            busy_cycles;
        logic          fail;
        logic [AW-1:0] fail_addr;
        logic [2:0]    fail_elem;
        logic [7:0]    fail_count;
    } exp_res_t;

    exp_op_t  exp_ops[$];
    obs_op_t  obs_ops[$];
    exp_res_t exp_res[$];
    int       busy_cycles;
    int       csb_bad;
    logic     pre_fail;
    logic     fault_on;

    logic [DW-1:0] mem [0:15];

    sram_march_bist dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .chip_sel   (chip_sel),
        .last_addr  (last_addr),
        .pattern    (pattern),
        .cmp_mask   (cmp_mask),
        .dout       (dout),
        .csb        (csb),
        .web        (web),
        .wmask      (wmask),
        .addr       (addr),
        .din        (din),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    // SRAM with registered read data; address 2 bit 0 is stuck at 0 when fault_on.
    always @(posedge clk) begin
        if (csb != '1) begin
            if (!web) mem[addr[3:0]] <= (fault_on && addr == 16'd2) ? (din & 32'hFFFF_FFFE) : din;
            else      dout <= mem[addr[3:0]];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_expected(input logic [AW-1:0] last, input logic [DW-1:0] pat,
                                 input logic [DW-1:0] mask, input logic faulty, input logic with_ops);
        exp_res_t      r;
        exp_op_t       op;
        int            n;
        logic [AW-1:0] a;
        logic [DW-1:0] rv, wv, stored;
        n = int'(last) + 1;
        r.busy_cycles = 10 * n + 1;
        r.fail        = 1'b0;
        r.fail_addr   = '0;
        r.fail_elem   = '0;
        r.fail_count  = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                a  = (e >= 3) ? 16'(int'(last) - k) : 16'(k);
                rv = (e == 2 || e == 4) ? ~pat : pat;
                wv = (e == 1 || e == 3) ? ~pat : pat;
                if (e != 0) begin
                    stored = (faulty && a == 16'd2) ? (rv & 32'hFFFF_FFFE) : rv;
                    if (((stored ^ rv) & mask) != 0) begin
                        if (!r.fail) begin
                            r.fail      = 1'b1;
                            r.fail_addr = a;
                            r.fail_elem = 3'(e);
                        end
                        if (r.fail_count != 8'hFF) r.fail_count = r.fail_count + 8'd1;
                    end
                    if (with_ops) begin
                        op.a = a; op.w = 1'b0; op.d = '0;
                        exp_ops.push_back(op);
                    end
                end
                if (e != 5 && with_ops) begin
                    op.a = a; op.w = 1'b1; op.d = wv;
                    exp_ops.push_back(op);
                end
            end
        end
        exp_res.push_back(r);
    endtask

    task automatic drive_run(input logic [AW-1:0] last, input logic [3:0] sel, input logic [DW-1:0] pat,
                             input logic [DW-1:0] mask, input int extra_start_at, input int reset_at);
        obs_op_t o;
        obs_ops.delete();
        busy_cycles = 0;
        csb_bad     = 0;
        @(negedge clk);
        chip_sel  = sel;
        last_addr = last;
        pattern   = pat;
        cmp_mask  = mask;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < RUN_BOUND; c++) begin
            if (c == reset_at) begin
                pre_fail = fail;
                #1 reset_n = 1'b0;
                break;
            end
            if (!busy) break;
            busy_cycles++;
            if (csb !== '1) begin
                o.a = addr; o.web = web; o.din = din; o.wmask = wmask; o.csb = csb;
                obs_ops.push_back(o);
                if (csb !== ~(16'h0001 << sel)) csb_bad++;
            end
            start = (c == extra_start_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (csb !== '1 || web !== 1'b1 || wmask !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_port_ctrl: got csb=%h web=%b wmask=%h want csb=ffff web=1 wmask=0", csb, web, wmask);
        end
        checks++;
        if (addr !== '0 || din !== '0) begin
            failures++;
            $display("[TB] FAIL reset_port_data: got addr=%h din=%h want 0 0", addr, din);
        end
        checks++;
        if ({busy, done, fail} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got busy/done/fail=%b want 000", {busy, done, fail});
        end
        checks++;
        if (fail_addr !== '0 || fail_elem !== '0 || fail_count !== '0) begin
            failures++;
            $display("[TB] FAIL reset_fail_info: got %h/%0d/%0d want 0/0/0", fail_addr, fail_elem, fail_count);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_fault_free();
        exp_res_t r;
        exp_op_t  e;
        obs_op_t  o;
        fault_on = 1'b0;
        push_expected(16'd3, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drive_run(16'd3, 4'd1, 32'h0, 32'hFFFF_FFFF, -1, -1);
        r = exp_res.pop_front();
        checks++;
        if (busy_cycles != r.busy_cycles) begin
            failures++;
            $display("[TB] FAIL ff_busy_cycles: got %0d want %0d", busy_cycles, r.busy_cycles);
        end
        checks++;
        if (done !== 1'b1 || fail !== r.fail || fail_count !== r.fail_count) begin
            failures++;
            $display("[TB] FAIL ff_status: got done=%b fail=%b cnt=%0d want done=1 fail=%b cnt=%0d",
                     done, fail, fail_count, r.fail, r.fail_count);
        end
        checks++;
        if (csb_bad != 0) begin
            failures++;
            $display("[TB] FAIL ff_csb_only_bit1: got %0d bad cycles want 0", csb_bad);
        end
        checks++;
        if (obs_ops.size() != exp_ops.size()) begin
            failures++;
            $display("[TB] FAIL ff_op_count: got %0d want %0d", obs_ops.size(), exp_ops.size());
        end
        while (obs_ops.size() > 0 && exp_ops.size() > 0) begin
            o = obs_ops.pop_front();
            e = exp_ops.pop_front();
            checks++;
            if (o.a !== e.a || o.web !== !e.w || o.csb !== 16'hFFFD ||
                (e.w && (o.din !== e.d || o.wmask !== 4'hF))) begin
                failures++;
                $display("[TB] FAIL ff_op: got a=%0d web=%b din=%h wm=%h csb=%h want a=%0d web=%b din=%h wm=f csb=fffd",
                         o.a, o.web, o.din, o.wmask, o.csb, e.a, !e.w, e.d);
            end
        end
        exp_ops.delete();
    endtask

    task automatic test_stuck_fault();
        exp_res_t r;
        fault_on = 1'b1;
        push_expected(16'd3, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drive_run(16'd3, 4'd1, 32'h0, 32'hFFFF_FFFF, -1, -1);
        r = exp_res.pop_front();
        checks++;
        if (done !== 1'b1 || fail !== r.fail) begin
            failures++;
            $display("[TB] FAIL stuck_fail_flag: got done=%b fail=%b want done=1 fail=%b", done, fail, r.fail);
        end
        checks++;
        if (fail_addr !== r.fail_addr || fail_elem !== r.fail_elem) begin
            failures++;
            $display("[TB] FAIL stuck_location: got addr=%0d elem=%0d want addr=%0d elem=%0d",
                     fail_addr, fail_elem, r.fail_addr, r.fail_elem);
        end
        checks++;
        if (fail_count !== r.fail_count) begin
            failures++;
            $display("[TB] FAIL stuck_count: got %0d want %0d", fail_count, r.fail_count);
        end
        push_expected(16'd3, 32'h0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        drive_run(16'd3, 4'd1, 32'h0, 32'hFFFF_FFFE, -1, -1);
        r = exp_res.pop_front();
        checks++;
        if (done !== 1'b1 || fail !== r.fail || fail_count !== r.fail_count) begin
            failures++;
            $display("[TB] FAIL masked_fault: got done=%b fail=%b cnt=%0d want done=1 fail=%b cnt=%0d",
                     done, fail, fail_count, r.fail, r.fail_count);
        end
        fault_on = 1'b0;
    endtask

    task automatic test_address_order();
        exp_res_t r;
        exp_op_t  e;
        obs_op_t  o;
        fault_on = 1'b0;
        push_expected(16'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive_run(16'd0, 4'd1, 32'h1234_5678, 32'hFFFF_FFFF, -1, -1);
        r = exp_res.pop_front();
        checks++;
        if (busy_cycles != r.busy_cycles || done !== 1'b1 || fail !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_addr_run: got busy=%0d done=%b fail=%b want busy=%0d done=1 fail=0",
                     busy_cycles, done, fail, r.busy_cycles);
        end
        push_expected(16'd3, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drive_run(16'd3, 4'd5, 32'hA5A5_5A5A, 32'hFFFF_FFFF, -1, -1);
        r = exp_res.pop_front();
        checks++;
        if (obs_ops.size() < 28) begin
            failures++;
            $display("[TB] FAIL e3_op_count: got %0d want at least 28", obs_ops.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_ops[20 + 2 * k].a !== 16'(3 - k) || obs_ops[21 + 2 * k].a !== 16'(3 - k)) begin
                    failures++;
                    $display("[TB] FAIL e3_descending[%0d]: got %0d,%0d want %0d", k,
                             obs_ops[20 + 2 * k].a, obs_ops[21 + 2 * k].a, 3 - k);
                end
            end
        end
        checks++;
        if (busy_cycles != r.busy_cycles || fail !== r.fail) begin
            failures++;
            $display("[TB] FAIL order_run: got busy=%0d fail=%b want busy=%0d fail=%b",
                     busy_cycles, fail, r.busy_cycles, r.fail);
        end
        while (obs_ops.size() > 0 && exp_ops.size() > 0) begin
            o = obs_ops.pop_front();
            e = exp_ops.pop_front();
            checks++;
            if (o.a !== e.a || o.web !== !e.w || o.csb !== 16'hFFDF ||
                (e.w && (o.din !== e.d || o.wmask !== 4'hF))) begin
                failures++;
                $display("[TB] FAIL order_op: got a=%0d web=%b din=%h csb=%h want a=%0d web=%b din=%h csb=ffdf",
                         o.a, o.web, o.din, o.csb, e.a, !e.w, e.d);
            end
        end
        exp_ops.delete();
    endtask

    task automatic test_start_while_busy();
        exp_res_t r;
        push_expected(16'd3, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive_run(16'd3, 4'd1, 32'h0, 32'hFFFF_FFFF, 10, -1);
        r = exp_res.pop_front();
        checks++;
        if (busy_cycles != r.busy_cycles || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_while_busy: got busy=%0d done=%b want busy=%0d done=1",
                     busy_cycles, done, r.busy_cycles);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_res_t r;
        fault_on = 1'b1;
        drive_run(16'd3, 4'd1, 32'h0, 32'hFFFF_FFFF, -1, 20);
        #1;
        checks++;
        if (pre_fail !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midrun_prefail: got %b want 1", pre_fail);
        end
        checks++;
        if (csb !== '1 || web !== 1'b1 || wmask !== 4'h0 || addr !== '0 || din !== '0) begin
            failures++;
            $display("[TB] FAIL midrun_async_port: got csb=%h web=%b wm=%h addr=%h din=%h want ffff 1 0 0 0",
                     csb, web, wmask, addr, din);
        end
        checks++;
        if ({busy, done, fail} !== 3'b000 || fail_addr !== '0 || fail_elem !== '0 || fail_count !== '0) begin
            failures++;
            $display("[TB] FAIL midrun_async_status: got b/d/f=%b info=%h/%0d/%0d want 000 0/0/0",
                     {busy, done, fail}, fail_addr, fail_elem, fail_count);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        fault_on = 1'b0;
        push_expected(16'd3, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive_run(16'd3, 4'd1, 32'h0, 32'hFFFF_FFFF, -1, -1);
        r = exp_res.pop_front();
        checks++;
        if (busy_cycles != r.busy_cycles || done !== 1'b1 || fail !== r.fail) begin
            failures++;
            $display("[TB] FAIL after_reset_run: got busy=%0d done=%b fail=%b want busy=%0d done=1 fail=%b",
                     busy_cycles, done, fail, r.busy_cycles, r.fail);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        chip_sel  = '0;
        last_addr = '0;
        pattern   = '0;
        cmp_mask  = '0;
        fault_on  = 1'b0;
        pre_fail  = 1'b0;
        test_reset();
        test_fault_free();
        test_stuck_fault();
        test_address_order();
        test_start_while_busy();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
